// File: rtl/btn_pkg.sv
// Shared types and default parameter values for the button debounce controller.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } btn_state_t;

    localparam int unsigned DEF_N_BTN        = 4;
    localparam int unsigned DEF_TICK_DIV     = 10;
    localparam int unsigned DEF_STABLE_TICKS = 4;
    localparam int unsigned DEF_LONG_TICKS   = 200;

endpackage

// File: rtl/debounce_tick_gen.sv
// Clock-enable divider: one-clk-wide tick once every TICK_DIV cycles.
module debounce_tick_gen
    import btn_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Free-running 0..TICK_DIV-1 counter, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/button_debounce_ctrl.sv
// Multi-channel push-button debouncer: shared sample tick, per-bit
// 2-flop synchronizer and one debounce/long-press FSM per channel.
module button_debounce_ctrl
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN        = DEF_N_BTN,
    parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_press,
    output logic             sample_tick
);

    localparam int unsigned DW = $clog2(STABLE_TICKS + 1);
    localparam int unsigned HW = $clog2(LONG_TICKS + 1);
    localparam logic [DW-1:0] D_STABLE = DW'(STABLE_TICKS);
    localparam logic [HW-1:0] H_LONG   = HW'(LONG_TICKS);

    logic             w_tick;
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    debounce_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign sample_tick = w_tick;

    // Two-stage synchronizer for the asynchronous raw inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_state_t    r_state;
        logic [DW-1:0] r_dcnt;
        logic [HW-1:0] r_hcnt;
        logic          r_level;
        logic          r_press;
        logic          r_rel;
        logic          r_long;
        logic [DW-1:0] w_dcnt_inc;
        logic [HW-1:0] w_hcnt_inc;
        logic          w_sync;

        assign w_sync     = r_sync2[g];
        assign w_dcnt_inc = r_dcnt + DW'(1);
        assign w_hcnt_inc = r_hcnt + HW'(1);

        // Debounce FSM: advances only on sample ticks; pulse outputs are one clk wide.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= IDLE;
                r_dcnt  <= '0;
                r_hcnt  <= '0;
                r_level <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_long  <= 1'b0;
            end else begin
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_long  <= 1'b0;
                if (w_tick) begin
                    case (r_state)
                        IDLE: begin
                            if (w_sync) begin
                                r_state <= PRESS_PEND;
                                r_dcnt  <= DW'(1);
                            end
                        end
                        PRESS_PEND: begin
                            if (w_sync) begin
                                if (w_dcnt_inc == D_STABLE) begin
                                    r_state <= PRESSED;
                                    r_dcnt  <= '0;
                                    r_hcnt  <= '0;
                                    r_level <= 1'b1;
                                    r_press <= 1'b1;
                                end else begin
                                    r_dcnt <= w_dcnt_inc;
                                end
                            end else begin
                                r_state <= IDLE;
                                r_dcnt  <= '0;
                            end
                        end
                        PRESSED: begin
                            if (w_sync) begin
                                // Saturating hold count; the pulse fires only on the step into LONG_TICKS.
                                if (r_hcnt != H_LONG) begin
                                    r_hcnt <= w_hcnt_inc;
                                    if (w_hcnt_inc == H_LONG) begin
                                        r_long <= 1'b1;
                                    end
                                end
                            end else begin
                                r_state <= RELEASE_PEND;
                                r_dcnt  <= DW'(1);
                            end
                        end
                        RELEASE_PEND: begin
                            if (!w_sync) begin
                                if (w_dcnt_inc == D_STABLE) begin
                                    r_state <= IDLE;
                                    r_dcnt  <= '0;
                                    r_hcnt  <= '0;
                                    r_level <= 1'b0;
                                    r_rel   <= 1'b1;
                                end else begin
                                    r_dcnt <= w_dcnt_inc;
                                end
                            end else begin
                                r_state <= PRESSED;
                                r_dcnt  <= '0;
                            end
                        end
                        default: begin
                            r_state <= IDLE;
                            r_dcnt  <= '0;
                        end
                    endcase
                end
            end
        end

        assign btn_level[g]     = r_level;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_rel;
        assign long_press[g]    = r_long;
    end

endmodule
